// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: scans a COLS x ROWS active-low key matrix, debounces each key
// and queues {pressed, key_index} events in a FIFO read over valid/ready.
module key_matrix_scanner #(
    parameter int COLS       = 4,
    parameter int ROWS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_SCANS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            en,
    output logic [COLS-1:0]                 key_col,
    input  logic [ROWS-1:0]                 key_row,
    output logic [COLS*ROWS-1:0]            key_state,
    output logic                            evt_valid,
    output logic [$clog2(COLS*ROWS):0]      evt_data,
    input  logic                            evt_ready,
    output logic                            overflow,
    input  logic                            overflow_clr
);
    localparam int NK = COLS * ROWS;
    localparam int KW = $clog2(NK);
    localparam int CW = $clog2(COLS);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int NW = $clog2(DEB_SCANS + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] EVAL   = 2'd2;

    logic [ROWS-1:0] sync1_q, sync2_q, sample_q, sample_d;
    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [DW-1:0]   div_q, div_d;
    logic [RW-1:0]   row_q, row_d;
    logic [NW-1:0]   cnt_q [NK];
    logic [NW-1:0]   cnt_d [NK];
    logic [NK-1:0]   key_state_q, key_state_d;
    logic [KW:0]     mem_q [FIFO_DEPTH];
    logic [KW:0]     mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]     fill_q, fill_d;
    logic            overflow_q, overflow_d;
    logic [KW-1:0]   key_idx;
    logic            push, pop, full, do_push, drop;
    logic [KW:0]     push_data;

    // One key is evaluated per EVAL cycle, so at most one push per cycle.
    always_comb begin
        key_idx     = KW'(int'(col_q) * ROWS + int'(row_q));
        state_d     = state_q;
        col_d       = col_q;
        div_d       = div_q;
        row_d       = row_q;
        sample_d    = sample_q;
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        push        = 1'b0;
        push_data   = '0;
        if (state_q == IDLE && en)
            state_d = SETTLE;
        if (state_q == SETTLE) begin
            if (div_q == DW'(SCAN_DIV - 1)) begin
                div_d    = '0;
                sample_d = ~sync2_q;
                state_d  = EVAL;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
        if (state_q == EVAL) begin
            if (sample_q[row_q] == key_state_q[key_idx]) begin
                cnt_d[key_idx] = '0;
            end else if (cnt_q[key_idx] == NW'(DEB_SCANS - 1)) begin
                cnt_d[key_idx]       = '0;
                key_state_d[key_idx] = ~key_state_q[key_idx];
                push                 = 1'b1;
                push_data            = {~key_state_q[key_idx], key_idx};
            end else begin
                cnt_d[key_idx] = cnt_q[key_idx] + 1'b1;
            end
            if (row_q == RW'(ROWS - 1)) begin
                row_d   = '0;
                col_d   = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
                state_d = SETTLE;
            end else begin
                row_d = row_q + 1'b1;
            end
        end
        // Disabling wins over the scan but lets this cycle's key update and push land.
        if (!en) begin
            state_d = IDLE;
            col_d   = '0;
            div_d   = '0;
            row_d   = '0;
            for (int i = 0; i < NK; i++)
                cnt_d[i] = '0;
        end
    end

    always_comb begin
        full       = fill_q == (PW+1)'(FIFO_DEPTH);
        pop        = evt_valid & evt_ready;
        do_push    = push & (~full | pop);
        drop       = push & full & ~pop;
        wr_d       = wr_q + PW'(do_push);
        rd_d       = rd_q + PW'(pop);
        fill_d     = fill_q + (PW+1)'(do_push) - (PW+1)'(pop);
        overflow_d = drop | (overflow_q & ~overflow_clr);
        mem_d      = mem_q;
        if (do_push)
            mem_d[wr_q] = push_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            sample_q    <= '0;
            state_q     <= IDLE;
            col_q       <= '0;
            div_q       <= '0;
            row_q       <= '0;
            key_state_q <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            fill_q      <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < NK; i++)
                cnt_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            sync1_q     <= key_row;
            sync2_q     <= sync1_q;
            sample_q    <= sample_d;
            state_q     <= state_d;
            col_q       <= col_d;
            div_q       <= div_d;
            row_q       <= row_d;
            key_state_q <= key_state_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            fill_q      <= fill_d;
            overflow_q  <= overflow_d;
            cnt_q       <= cnt_d;
            mem_q       <= mem_d;
        end
    end

    assign key_col   = (state_q == IDLE) ? '1 : ~(COLS'(1) << col_q);
    assign key_state = key_state_q;
    assign evt_valid = fill_q != '0;
    assign evt_data  = mem_q[rd_q];
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb_key_matrix_scanner: physical key matrix model, per-key debounce reference model and
// an event scoreboard drained by an independent monitor with randomized ready.
module tb_key_matrix_scanner;
    localparam int COLS = 4, ROWS = 4, SCAN_DIV = 4, DEB = 4, DEPTH = 8, NK = COLS * ROWS;

    logic clk = 0, resetn = 0, en = 0, evt_ready = 0, overflow_clr = 0;
    logic evt_valid, overflow;
    logic [COLS-1:0] key_col, col_prev;
    logic [ROWS-1:0] key_row;
    logic [NK-1:0] key_state;
    logic [4:0] evt_data;
    logic [NK-1:0] pressed = '0;

    bit [NK-1:0] m_state = '0;
    int m_cnt [NK];
    bit m_ovf = 0;
    logic [4:0] exp_q [$];
    int ready_mode = 2;
    int n_checks = 0, n_pass = 0;

    key_matrix_scanner #(.COLS(COLS), .ROWS(ROWS), .SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB),
                         .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .en(en), .key_col(key_col), .key_row(key_row),
        .key_state(key_state), .evt_valid(evt_valid), .evt_data(evt_data),
        .evt_ready(evt_ready), .overflow(overflow), .overflow_clr(overflow_clr));

    always #5 clk = ~clk;

    // A pressed key shorts its row to the column currently driven low.
    always_comb begin
        key_row = '1;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (!key_col[c] && pressed[c*ROWS+r]) key_row[r] = 1'b0;
    end

    always @(posedge clk) col_prev <= key_col;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        evt_ready = (ready_mode == 2) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (resetn && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL evt_unexpected: got %0h expected no event", evt_data);
            end else begin
                check("evt", {27'd0, evt_data}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    // Reference: one column scan applies the debounce rule to each of its keys in row order.
    task automatic model_col(input int c);
        for (int r = 0; r < ROWS; r++) begin
            int k = c * ROWS + r;
            if (pressed[k] == m_state[k]) m_cnt[k] = 0;
            else if (++m_cnt[k] == DEB) begin
                m_cnt[k] = 0;
                m_state[k] = ~m_state[k];
                if (ready_mode == 0 && exp_q.size() >= DEPTH) m_ovf = 1;
                else exp_q.push_back({m_state[k], 4'(k)});
            end
        end
    endtask

    task automatic clear_cnt();
        for (int k = 0; k < NK; k++) m_cnt[k] = 0;
    endtask

    task automatic wait_scan(output int el);
        bit found = 0;
        el = 0;
        while (!found && el < 100) begin
            @(negedge clk);
            el++;
            found = (key_col == 4'b1110) && (col_prev != 4'b1110);
        end
        if (!found) begin
            n_checks++;
            $display("FAIL scan_timeout: got no column-0 start expected one within 100 cycles");
        end
    endtask

    task automatic body(input logic [NK-1:0] pat, input int ncols);
        check("key_state", {16'd0, key_state}, {16'd0, m_state});
        pressed = pat;
        for (int c = 0; c < ncols; c++) model_col(c);
    endtask

    task automatic scan(input logic [NK-1:0] pat);
        int el;
        wait_scan(el);
        body(pat, COLS);
    endtask

    initial begin
        int el;
        logic [NK-1:0] pat;
        clear_cnt();
        repeat (3) @(negedge clk);
        check("rst_key_col", {28'd0, key_col}, 32'hF);
        check("rst_key_state", {16'd0, key_state}, 32'h0);
        check("rst_evt_valid", {31'd0, evt_valid}, 32'h0);
        check("rst_overflow", {31'd0, overflow}, 32'h0);
        resetn = 1;
        @(negedge clk);
        en = 1;
        // key 6 press and release, then a short glitch, then keys 4,5,7 together
        repeat (DEB + 2) scan(16'h0040);
        repeat (DEB + 1) scan(16'h0000);
        repeat (DEB - 1) scan(16'h0040);
        repeat (DEB + 1) scan(16'h0000);
        repeat (DEB) scan(16'h00B0);
        repeat (DEB + 1) scan(16'h0000);
        // overflow with ready held low: nine changes into eight entries
        ready_mode = 0;
        repeat (DEB) scan(16'h01FF);
        wait_scan(el);
        check("overflow_set", {31'd0, overflow}, {31'd0, m_ovf});
        check("full_valid", {31'd0, evt_valid}, 32'h1);
        body(16'h01FF, COLS);
        overflow_clr = 1;
        @(negedge clk);
        overflow_clr = 0;
        m_ovf = 0;
        check("overflow_clr", {31'd0, overflow}, {31'd0, m_ovf});
        ready_mode = 1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) scan(16'h01FF);
        ready_mode = 2;
        repeat (DEB + 1) scan(16'h0000);
        // key 10 (column 2) part-debounced, then en dropped in column 2 settle
        repeat (DEB - 1) scan(16'h0400);
        wait_scan(el);
        body(16'h0400, 2);
        repeat (18) @(negedge clk);
        en = 0;
        @(negedge clk);
        check("en_off_key_col", {28'd0, key_col}, 32'hF);
        clear_cnt();
        repeat (3) @(negedge clk);
        en = 1;
        wait_scan(el);
        check("en_restart_col0", el, 1);
        body(16'h0400, COLS);
        repeat (DEB) scan(16'h0400);
        repeat (DEB + 1) scan(16'h0000);
        // async reset in column-0 EVAL with three events queued
        ready_mode = 0;
        repeat (DEB) scan(16'h00B0);
        wait_scan(el);
        check("queued_valid", {31'd0, evt_valid}, 32'h1);
        repeat (5) @(negedge clk);
        resetn = 0;
        #1;
        check("arst_evt_valid", {31'd0, evt_valid}, 32'h0);
        check("arst_key_state", {16'd0, key_state}, 32'h0);
        check("arst_key_col", {28'd0, key_col}, 32'hF);
        exp_q.delete();
        m_state = '0;
        m_ovf = 0;
        clear_cnt();
        pressed = '0;
        @(negedge clk);
        resetn = 1;
        ready_mode = 1;
        wait_scan(el);
        check("arst_restart_col0", el, 1);
        body(16'h0000, COLS);
        // random key activity with random ready
        for (int i = 0; i < 60; i++) begin
            pat = pressed;
            if ($urandom_range(0, 2) == 0) pat[$urandom_range(0, NK - 1)] ^= 1'b1;
            scan(pat);
        end
        ready_mode = 2;
        for (int i = 0; i < 4; i++) scan(pressed);
        check("queue_drained", exp_q.size(), 0);
        check("final_overflow", {31'd0, overflow}, {31'd0, m_ovf});
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
